stopwatch_core: RTL and testbench

- Time-base stage directly upstream of the 8-digit scanned seven-segment display.
- Runs an 8-digit BCD stopwatch (HH MM SS cc) with start/stop, lap freeze and clear, using a 100 Hz tick derived from the system clock.
- Presents all eight BCD digits in parallel; the display stage's 8:1 digit selector consumes them under its scan counter.

---
 rtl/stopwatch_core_pkg.sv | 21 ++
 rtl/stopwatch_core_if.sv | 28 ++
 rtl/bcd_pair_counter.sv | 43 ++++
 rtl/stopwatch_core.sv | 119 +++++++++++
 tb/tb_stopwatch_core.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the stopwatch time base: FSM encodings, digit-field
// positions inside bcd_out and the fixed digit-pair limits.
package stopwatch_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    // LSB of each two-digit field in bcd_out (H1H0 MM1M0 S1S0 C1C0).
    localparam int HOUR_LSB  = 24;
    localparam int MIN_LSB   = 16;
    localparam int SEC_LSB   = 8;
    localparam int CENTI_LSB = 0;

    localparam int CENTI_MAX = 99;
    localparam int SEXA_MAX  = 59;

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/display bundle between the tick divider, key debouncers and the
// stopwatch core, plus the display-facing digit and status outputs.
interface stopwatch_core_if;
    import stopwatch_core_pkg::*;

    // tick, key_ss and key_lap are single-cycle pulses with no back-pressure:
    // a pulse is consumed on the rising cp edge where it is high, and the
    // outputs are pure register functions, valid every cycle.
    logic        tick;
    logic        key_ss;
    logic        key_lap;
    logic [31:0] bcd_out;
    logic        running;
    logic        lap_active;
    logic        ovf;
    sw_state_t   state;

    modport master (
        output tick, key_ss, key_lap,
        input  bcd_out, running, lap_active, ovf, state
    );

    modport slave (
        input  tick, key_ss, key_lap,
        output bcd_out, running, lap_active, ovf, state
    );

endinterface

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that rolls over to 00 after MAX; carry flags the MAX
// value so the next stage can be enabled on the same tick.
module bcd_pair_counter #(
    parameter int MAX = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] digits,
    output logic       carry
);

    localparam logic [3:0] MAX_TENS = 4'(MAX / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX % 10);

    logic [3:0] tens;
    logic [3:0] ones;

    assign carry  = (tens == MAX_TENS) && (ones == MAX_ONES);
    assign digits = {tens, ones};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (en) begin
            if (carry) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// HH:MM:SS.cc BCD stopwatch with start/stop, lap freeze and clear, counting
// on the 100 Hz tick; the lap latch freezes the display while counting goes on.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int HOUR_LIMIT = 99
) (
    input logic              cp,
    input logic              nCR,
    stopwatch_core_if.slave  bus
);

    sw_state_t   state;
    sw_state_t   state_next;
    logic        capture;
    logic        clr_all;
    logic        count_en;
    logic [31:0] live;
    logic [31:0] lap_q;
    logic        ovf_q;

    logic [7:0]  c_digits, s_digits, m_digits, h_digits;
    logic        c_carry, s_carry, m_carry, h_carry;
    logic        s_en, m_en, h_en, wrap;

    always_ff @(posedge cp or negedge nCR) begin
        if (!nCR) state <= ST_IDLE;
        else      state <= state_next;
    end

    // key_ss always takes priority; a simultaneous key_lap is dropped.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        clr_all    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.key_ss) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.key_ss) begin
                    state_next = ST_PAUSE;
                end else if (bus.key_lap) begin
                    state_next = ST_LAP;
                    capture    = 1'b1;
                end
            end
            ST_LAP: begin
                if (bus.key_ss)       state_next = ST_PAUSE;
                else if (bus.key_lap) state_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (bus.key_ss) begin
                    state_next = ST_RUN;
                end else if (bus.key_lap) begin
                    state_next = ST_IDLE;
                    clr_all    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Ticks are judged against the pre-transition state.
    assign count_en = bus.tick && ((state == ST_RUN) || (state == ST_LAP));
    assign s_en     = count_en && c_carry;
    assign m_en     = s_en && s_carry;
    assign h_en     = m_en && m_carry;
    assign wrap     = h_en && h_carry;

    bcd_pair_counter #(.MAX(CENTI_MAX)) u_centi (
        .clk(cp), .rst_n(nCR), .en(count_en), .clr(clr_all),
        .digits(c_digits), .carry(c_carry)
    );

    bcd_pair_counter #(.MAX(SEXA_MAX)) u_sec (
        .clk(cp), .rst_n(nCR), .en(s_en), .clr(clr_all),
        .digits(s_digits), .carry(s_carry)
    );

    bcd_pair_counter #(.MAX(SEXA_MAX)) u_min (
        .clk(cp), .rst_n(nCR), .en(m_en), .clr(clr_all),
        .digits(m_digits), .carry(m_carry)
    );

    bcd_pair_counter #(.MAX(HOUR_LIMIT)) u_hour (
        .clk(cp), .rst_n(nCR), .en(h_en), .clr(clr_all),
        .digits(h_digits), .carry(h_carry)
    );

    always_comb begin
        live                   = '0;
        live[HOUR_LSB  +: 8]   = h_digits;
        live[MIN_LSB   +: 8]   = m_digits;
        live[SEC_LSB   +: 8]   = s_digits;
        live[CENTI_LSB +: 8]   = c_digits;
    end

    // Capture samples the register value, so a coincident tick is not included.
    always_ff @(posedge cp or negedge nCR) begin
        if (!nCR) begin
            lap_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (clr_all)      lap_q <= '0;
            else if (capture) lap_q <= live;

            if (clr_all)   ovf_q <= 1'b0;
            else if (wrap) ovf_q <= 1'b1;
        end
    end

    assign bus.state      = state;
    assign bus.running    = (state == ST_RUN) || (state == ST_LAP);
    assign bus.lap_active = (state == ST_LAP);
    assign bus.ovf        = ovf_q;
    assign bus.bcd_out    = (state == ST_LAP) ? lap_q : live;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: one default instance and one with
// HOUR_LIMIT=1 for the wrap/overflow path.
module tb_stopwatch_core;
    import stopwatch_core_pkg::*;

    logic cp;
    logic nCR;
    int   total = 0;
    int   bad   = 0;

    stopwatch_core_if bus_a ();
    stopwatch_core_if bus_b ();

    stopwatch_core #(.HOUR_LIMIT(99)) u_dut_a (.cp(cp), .nCR(nCR), .bus(bus_a));
    stopwatch_core #(.HOUR_LIMIT(1))  u_dut_b (.cp(cp), .nCR(nCR), .bus(bus_b));

    // clock / reset
    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit on_b, input logic [31:0] exp_bcd,
                           input logic exp_run, input logic exp_lap, input logic exp_ovf);
        if (on_b) begin
            chk({tag, ".bcd"}, bus_b.bcd_out, exp_bcd);
            chk({tag, ".run"}, 32'(bus_b.running), 32'(exp_run));
            chk({tag, ".lap"}, 32'(bus_b.lap_active), 32'(exp_lap));
            chk({tag, ".ovf"}, 32'(bus_b.ovf), 32'(exp_ovf));
        end else begin
            chk({tag, ".bcd"}, bus_a.bcd_out, exp_bcd);
            chk({tag, ".run"}, 32'(bus_a.running), 32'(exp_run));
            chk({tag, ".lap"}, 32'(bus_a.lap_active), 32'(exp_lap));
            chk({tag, ".ovf"}, 32'(bus_a.ovf), 32'(exp_ovf));
        end
    endtask

    // driver tasks: called at a falling edge, return at a falling edge
    task automatic do_ticks(input bit on_b, input int n);
        if (on_b) bus_b.tick = 1'b1;
        else      bus_a.tick = 1'b1;
        repeat (n) @(negedge cp);
        bus_a.tick = 1'b0;
        bus_b.tick = 1'b0;
    endtask

    task automatic pulse(input bit on_b, input bit ss, input bit lap, input bit tk);
        if (on_b) begin
            bus_b.key_ss = ss; bus_b.key_lap = lap; bus_b.tick = tk;
        end else begin
            bus_a.key_ss = ss; bus_a.key_lap = lap; bus_a.tick = tk;
        end
        @(negedge cp);
        bus_a.key_ss = 1'b0; bus_a.key_lap = 1'b0; bus_a.tick = 1'b0;
        bus_b.key_ss = 1'b0; bus_b.key_lap = 1'b0; bus_b.tick = 1'b0;
    endtask

    initial begin
        nCR = 1'b0;
        bus_a.tick = 1'b0; bus_a.key_ss = 1'b0; bus_a.key_lap = 1'b0;
        bus_b.tick = 1'b0; bus_b.key_ss = 1'b0; bus_b.key_lap = 1'b0;
        #12;
        chk_out("reset_a", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_out("reset_b", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_state", 32'(bus_a.state), 32'(ST_IDLE));
        @(negedge cp);
        nCR = 1'b1;
        @(negedge cp);

        // basic run: 100 ticks = 1.00 s
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_state", 32'(bus_a.state), 32'(ST_RUN));
        do_ticks(1'b0, 100);
        chk_out("t1", 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0);

        // 59.99 then the carry into minutes
        do_ticks(1'b0, 5899);
        chk_out("t2_5999", 1'b0, 32'h0000_5999, 1'b1, 1'b0, 1'b0);
        do_ticks(1'b0, 1);
        chk_out("t2_carry", 1'b0, 32'h0001_0000, 1'b1, 1'b0, 1'b0);

        // pause then clear
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("pause", 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("clear", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("clear_state", 32'(bus_a.state), 32'(ST_IDLE));

        // lap freeze
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        do_ticks(1'b0, 250);
        chk_out("t3_250", 1'b0, 32'h0000_0250, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("t3_lap", 1'b0, 32'h0000_0250, 1'b1, 1'b1, 1'b0);
        do_ticks(1'b0, 100);
        chk_out("t3_frozen", 1'b0, 32'h0000_0250, 1'b1, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("t3_live", 1'b0, 32'h0000_0350, 1'b1, 1'b0, 1'b0);

        // lap with coincident tick: latch 3.50, live moves to 3.51
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("lap_tick", 1'b0, 32'h0000_0350, 1'b1, 1'b1, 1'b0);
        do_ticks(1'b0, 5);
        chk("lap_tick_frozen", bus_a.bcd_out, 32'h0000_0350);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("lap_tick_live", 1'b0, 32'h0000_0356, 1'b1, 1'b0, 1'b0);

        // key_ss in LAP goes to PAUSE with the live count shown
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        do_ticks(1'b0, 4);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("lap_to_pause", 1'b0, 32'h0000_0360, 1'b0, 1'b0, 1'b0);
        chk("lap_to_pause_st", 32'(bus_a.state), 32'(ST_PAUSE));

        // resume, then tick + key_ss: increment then pause
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        chk_out("tick_ss", 1'b0, 32'h0000_0361, 1'b0, 1'b0, 1'b0);

        // simultaneous keys in RUN: key_ss wins, no lap
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("resume_state", 32'(bus_a.state), 32'(ST_RUN));
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("both_keys", 1'b0, 32'h0000_0361, 1'b0, 1'b0, 1'b0);
        chk("both_keys_st", 32'(bus_a.state), 32'(ST_PAUSE));
        do_ticks(1'b0, 20);
        chk("pause_hold", bus_a.bcd_out, 32'h0000_0361);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("clear2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // IDLE ignores key_lap and ticks
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        do_ticks(1'b0, 10);
        chk_out("idle_ignore", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("idle_ignore_st", 32'(bus_a.state), 32'(ST_IDLE));

        // HOUR_LIMIT=1 wrap after 01:59:59.99
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        do_ticks(1'b1, 719999);
        chk_out("wrap_pre", 1'b1, 32'h0159_5999, 1'b1, 1'b0, 1'b0);
        do_ticks(1'b1, 1);
        chk_out("wrap", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        do_ticks(1'b1, 1);
        chk_out("wrap_cont", 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("wrap_pause", 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("ovf_clear", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-run, between clock edges
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        do_ticks(1'b0, 37);
        chk_out("pre_rst", 1'b0, 32'h0000_0037, 1'b1, 1'b0, 1'b0);
        @(posedge cp);
        #2;
        bus_a.tick = 1'b1;
        bus_a.key_ss = 1'b1;
        nCR = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge cp);
        chk_out("rst_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        bus_a.key_ss = 1'b0;
        nCR = 1'b1;
        repeat (5) @(negedge cp);
        bus_a.tick = 1'b0;
        chk_out("post_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_st", 32'(bus_a.state), 32'(ST_IDLE));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        do_ticks(1'b0, 3);
        chk_out("post_rst_run", 1'b0, 32'h0000_0003, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
